fooart16550_core: RTL and testbench

- Parametrised successor to the simulator host-link port; presents a 16550-compatible register map on the CPU bus.
- Adds TX/RX FIFOs, FIFO control, a character-timeout counter, prioritised interrupts, loopback, scratch and divisor-latch registers.
- The host side remains a parallel valid/ready byte stream to the simulator; no serialiser. Divisor and LCR values are stored only.

---
 rtl/fooart_pkg.sv | 48 ++++
 rtl/fooart_fifo.sv | 70 +++++++
 rtl/fooart16550_core.sv | 217 +++++++++++++++++++++
 tb/tb_fooart16550_core.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fooart_pkg.sv
// Shared constants for the 16550-style host-link UART.
// Register offsets, IIR codes, bit indices, trigger decode.
package fooart_pkg;

    localparam logic [2:0] ADDR_RBR = 3'd0;
    localparam logic [2:0] ADDR_IER = 3'd1;
    localparam logic [2:0] ADDR_IIR = 3'd2;
    localparam logic [2:0] ADDR_LCR = 3'd3;
    localparam logic [2:0] ADDR_MCR = 3'd4;
    localparam logic [2:0] ADDR_LSR = 3'd5;
    localparam logic [2:0] ADDR_MSR = 3'd6;
    localparam logic [2:0] ADDR_SCR = 3'd7;

    localparam logic [3:0] IIR_RLS  = 4'h6;
    localparam logic [3:0] IIR_RDA  = 4'h4;
    localparam logic [3:0] IIR_CTO  = 4'hC;
    localparam logic [3:0] IIR_THRE = 4'h2;
    localparam logic [3:0] IIR_NONE = 4'h1;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam int IER_RDA  = 0;
    localparam int IER_THRE = 1;
    localparam int IER_RLS  = 2;

    localparam int FCR_EN    = 0;
    localparam int FCR_RXCLR = 1;
    localparam int FCR_TXCLR = 2;

    localparam int MCR_LOOP = 4;
    localparam int LCR_DLAB = 7;

    // FCR[7:6] to RX trigger level in entries
    function automatic logic [4:0] trig_level(input logic [1:0] sel);
        logic [4:0] lvl;
        unique case (sel)
            2'b00:   lvl = 5'd1;
            2'b01:   lvl = 5'd4;
            2'b10:   lvl = 5'd8;
            default: lvl = 5'd14;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/fooart_fifo.sv
// Synchronous FIFO with a run-time depth limit.
// Limit of 1 gives single-entry 16450 behaviour.
module fooart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(DEPTH):0]   i_limit,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_q >= i_limit);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    assign push_ok = i_push & ~o_full & ~i_clr;
    assign pop_ok  = i_pop & ~o_empty & ~i_clr;

    // Occupancy next-state from accepted push/pop
    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and count; clear beats any same-cycle push
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/fooart16550_core.sv
// 16550-compatible register front end for the simulator host link.
// Host side is a parallel byte stream; divisor/LCR are storage only.
module fooart16550_core
    import fooart_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cs,
    input  logic [2:0] i_addr,
    input  logic       i_rd,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic [7:0] i_rx,
    input  logic       i_rx_valid,
    output logic       o_rx_ready,
    output logic [7:0] o_tx,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_int
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]    ier_q;
    logic [7:0]    lcr_q;
    logic [4:0]    mcr_q;
    logic [7:0]    scr_q;
    logic [7:0]    dll_q;
    logic [7:0]    dlm_q;
    logic          fcr_en_q;
    logic [1:0]    fcr_trig_q;
    logic          oe_q, oe_d;
    logic          thre_q, thre_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          int_q;

    logic          rd_en, wr_en, dlab, loop;
    logic          thr_wr, rbr_rd, iir_rd, lsr_rd;
    logic          ier_wr, fcr_wr, fcr_chg;
    logic [CW-1:0] limit, trig;

    logic          rx_clr, rx_push, rx_pop, rx_acc, rx_full, rx_empty;
    logic [7:0]    rx_din, rx_dout;
    logic [CW-1:0] rx_count;
    logic          tx_clr, tx_push, tx_pop, tx_acc, tx_full, tx_empty;
    logic [CW-1:0] tx_count;
    logic          tx_to_empty, ier_rise, tmo_hit;
    logic [3:0]    iir_id;
    logic [7:0]    lsr, iir;

    assign rd_en = i_cs & i_rd;
    assign wr_en = i_cs & i_wr;
    assign dlab  = lcr_q[LCR_DLAB];
    assign loop  = mcr_q[MCR_LOOP];

    assign thr_wr = wr_en & (i_addr == ADDR_RBR) & ~dlab;
    assign ier_wr = wr_en & (i_addr == ADDR_IER) & ~dlab;
    assign fcr_wr = wr_en & (i_addr == ADDR_IIR);
    assign rbr_rd = rd_en & (i_addr == ADDR_RBR) & ~dlab;
    assign iir_rd = rd_en & (i_addr == ADDR_IIR);
    assign lsr_rd = rd_en & (i_addr == ADDR_LSR);

    assign fcr_chg = fcr_wr & (i_data[FCR_EN] != fcr_en_q);
    assign rx_clr  = fcr_wr & (i_data[FCR_RXCLR] | fcr_chg);
    assign tx_clr  = fcr_wr & (i_data[FCR_TXCLR] | fcr_chg);

    assign limit = fcr_en_q ? CW'(FIFO_DEPTH) : CW'(1);
    assign trig  = fcr_en_q ? CW'(trig_level(fcr_trig_q)) : CW'(1);

    assign o_rx_ready = ~rx_full & ~loop;
    assign rx_push    = loop ? thr_wr : (i_rx_valid & o_rx_ready);
    assign rx_din     = loop ? i_data : i_rx;
    assign rx_pop     = rbr_rd & ~rx_empty;
    assign rx_acc     = rx_push & ~rx_full & ~rx_clr;

    assign o_tx_valid = ~tx_empty & ~loop;
    assign tx_push    = thr_wr & ~loop;
    assign tx_pop     = o_tx_valid & i_tx_ready;
    assign tx_acc     = tx_push & ~tx_full & ~tx_clr;

    assign tx_to_empty = ~tx_empty & (tx_clr |
                         (tx_pop & (tx_count == CW'(1)) & ~tx_acc));
    assign ier_rise = ier_wr & i_data[IER_THRE] & ~ier_q[IER_THRE] & tx_empty;
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES));

    fooart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (rx_clr),
        .i_push  (rx_push),
        .i_pop   (rx_pop),
        .i_data  (rx_din),
        .i_limit (limit),
        .o_data  (rx_dout),
        .o_count (rx_count),
        .o_full  (rx_full),
        .o_empty (rx_empty)
    );

    fooart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (tx_clr),
        .i_push  (tx_push),
        .i_pop   (tx_pop),
        .i_data  (i_data),
        .i_limit (limit),
        .o_data  (o_tx),
        .o_count (tx_count),
        .o_full  (tx_full),
        .o_empty (tx_empty)
    );

    // Highest-priority pending interrupt source
    always_comb begin
        if (oe_q & ier_q[IER_RLS])
            iir_id = IIR_RLS;
        else if ((rx_count >= trig) & ier_q[IER_RDA])
            iir_id = IIR_RDA;
        else if (tmo_hit & ier_q[IER_RDA])
            iir_id = IIR_CTO;
        else if (thre_q & ier_q[IER_THRE])
            iir_id = IIR_THRE;
        else
            iir_id = IIR_NONE;
    end

    assign iir = {fcr_en_q, fcr_en_q, 2'b00, iir_id};

    assign lsr = {1'b0, tx_empty, tx_empty, 3'b000, oe_q, ~rx_empty};

    // Next-state for overrun, THRE flag and timeout counter
    always_comb begin
        oe_d = oe_q;
        if (lsr_rd) oe_d = 1'b0;
        if (loop & thr_wr & rx_full) oe_d = 1'b1;

        thre_d = thre_q;
        if (thr_wr | (iir_rd & (iir_id == IIR_THRE))) thre_d = 1'b0;
        if (tx_to_empty | ier_rise) thre_d = 1'b1;

        tmo_d = '0;
        if (rx_acc | rx_pop)
            tmo_d = '0;
        else if ((rx_count != '0) & (rx_count < trig))
            tmo_d = tmo_hit ? tmo_q : tmo_q + TW'(1);
    end

    // Bus-visible configuration registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ier_q      <= 4'h0;
            lcr_q      <= 8'h00;
            mcr_q      <= 5'h00;
            scr_q      <= 8'h00;
            dll_q      <= 8'h01;
            dlm_q      <= 8'h00;
            fcr_en_q   <= 1'b0;
            fcr_trig_q <= 2'b00;
        end else if (wr_en) begin
            unique case (i_addr)
                ADDR_RBR: if (dlab) dll_q <= i_data;
                ADDR_IER: begin
                    if (dlab) dlm_q <= i_data;
                    else      ier_q <= i_data[3:0];
                end
                ADDR_IIR: begin
                    fcr_en_q   <= i_data[FCR_EN];
                    fcr_trig_q <= i_data[7:6];
                end
                ADDR_LCR: lcr_q <= i_data;
                ADDR_MCR: mcr_q <= i_data[4:0];
                ADDR_SCR: scr_q <= i_data;
                default:  ;
            endcase
        end
    end

    // Status flags, timeout counter and registered interrupt
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            oe_q   <= 1'b0;
            thre_q <= 1'b0;
            tmo_q  <= '0;
            int_q  <= 1'b0;
        end else begin
            oe_q   <= oe_d;
            thre_q <= thre_d;
            tmo_q  <= tmo_d;
            int_q  <= (iir_id != IIR_NONE);
        end
    end

    assign o_int = int_q;

    // Read-data mux, zero when not reading
    always_comb begin
        o_data = 8'h00;
        if (rd_en) begin
            unique case (i_addr)
                ADDR_RBR: o_data = dlab ? dll_q : (rx_empty ? 8'h00 : rx_dout);
                ADDR_IER: o_data = dlab ? dlm_q : {4'h0, ier_q};
                ADDR_IIR: o_data = iir;
                ADDR_LCR: o_data = lcr_q;
                ADDR_MCR: o_data = {3'b000, mcr_q};
                ADDR_LSR: o_data = lsr;
                ADDR_MSR: o_data = 8'h00;
                default:  o_data = scr_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fooart16550_core.sv
// Directed + randomized bench for fooart16550_core.
// Reference model keeps FIFOs as queues and registers as plain variables.
module tb_fooart16550_core;

    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_cs, i_rd, i_wr;
    logic [2:0] i_addr;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic [7:0] i_rx;
    logic       i_rx_valid;
    logic       o_rx_ready;
    logic [7:0] o_tx;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic       o_int;

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [3:0] m_ier;
    logic [7:0] m_lcr, m_scr, m_dll, m_dlm;
    logic [4:0] m_mcr;
    logic       m_fcr_en;
    logic [1:0] m_trig;
    logic       m_oe, m_thre;

    fooart16550_core #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_cs       (i_cs),
        .i_addr     (i_addr),
        .i_rd       (i_rd),
        .i_wr       (i_wr),
        .i_data     (i_data),
        .o_data     (o_data),
        .i_rx       (i_rx),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_tx       (o_tx),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_int      (o_int)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_ier = 4'h0; m_lcr = 8'h00; m_mcr = 5'h00; m_scr = 8'h00;
        m_dll = 8'h01; m_dlm = 8'h00; m_fcr_en = 1'b0; m_trig = 2'b00;
        m_oe = 1'b0; m_thre = 1'b0;
    endtask

    function automatic int depth();
        return m_fcr_en ? DEPTH : 1;
    endfunction

    function automatic int trigger();
        if (!m_fcr_en) return 1;
        case (m_trig)
            2'd0: return 1;
            2'd1: return 4;
            2'd2: return 8;
            default: return 14;
        endcase
    endfunction

    function automatic logic [7:0] exp_iir(input bit tmo);
        logic [3:0] id;
        if (m_oe && m_ier[2])                          id = 4'h6;
        else if (rxq.size() >= trigger() && m_ier[0])  id = 4'h4;
        else if (tmo && m_ier[0])                      id = 4'hC;
        else if (m_thre && m_ier[1])                   id = 4'h2;
        else                                           id = 4'h1;
        return {m_fcr_en, m_fcr_en, 2'b00, id};
    endfunction

    function automatic logic [7:0] exp_lsr();
        logic te;
        te = (txq.size() == 0);
        return {1'b0, te, te, 3'b000, m_oe, rxq.size() != 0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        bit chg;
        i_cs = 1'b1; i_wr = 1'b1; i_addr = a; i_data = d;
        @(posedge i_clk); #1;
        i_cs = 1'b0; i_wr = 1'b0;
        case (a)
            3'd0: begin
                if (m_lcr[7]) m_dll = d;
                else begin
                    m_thre = 1'b0;
                    if (m_mcr[4]) begin
                        if (rxq.size() < depth()) rxq.push_back(d);
                        else m_oe = 1'b1;
                    end else if (txq.size() < depth()) txq.push_back(d);
                end
            end
            3'd1: begin
                if (m_lcr[7]) m_dlm = d;
                else begin
                    if (d[1] && !m_ier[1] && txq.size() == 0) m_thre = 1'b1;
                    m_ier = d[3:0];
                end
            end
            3'd2: begin
                chg = (d[0] != m_fcr_en);
                if (chg || d[1]) rxq.delete();
                if ((chg || d[2]) && txq.size() > 0) begin
                    txq.delete();
                    m_thre = 1'b1;
                end
                m_fcr_en = d[0];
                m_trig = d[7:6];
            end
            3'd3: m_lcr = d;
            3'd4: m_mcr = d[4:0];
            3'd7: m_scr = d;
            default: ;
        endcase
    endtask

    task automatic rd_chk(input logic [2:0] a, input string tag, input bit tmo);
        logic [7:0] e;
        case (a)
            3'd0: e = m_lcr[7] ? m_dll : (rxq.size() > 0 ? rxq[0] : 8'h00);
            3'd1: e = m_lcr[7] ? m_dlm : {4'h0, m_ier};
            3'd2: e = exp_iir(tmo);
            3'd3: e = m_lcr;
            3'd4: e = {3'b000, m_mcr};
            3'd5: e = exp_lsr();
            3'd6: e = 8'h00;
            default: e = m_scr;
        endcase
        i_cs = 1'b1; i_rd = 1'b1; i_addr = a;
        #1;
        chk(tag, o_data, e);
        @(posedge i_clk); #1;
        i_cs = 1'b0; i_rd = 1'b0;
        if (a == 3'd0 && !m_lcr[7] && rxq.size() > 0) void'(rxq.pop_front());
        if (a == 3'd5) m_oe = 1'b0;
        if (a == 3'd2 && e[3:0] == 4'h2) m_thre = 1'b0;
    endtask

    task automatic hpush(input logic [7:0] b);
        bit rdy;
        rdy = (rxq.size() < depth()) && !m_mcr[4];
        i_rx = b; i_rx_valid = 1'b1;
        #1;
        chk("rx_ready", o_rx_ready, rdy);
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0;
        if (rdy) rxq.push_back(b);
    endtask

    task automatic hpop();
        chk("tx_valid", o_tx_valid, 1'b1);
        chk("tx_data", o_tx, txq[0]);
        i_tx_ready = 1'b1;
        @(posedge i_clk); #1;
        i_tx_ready = 1'b0;
        void'(txq.pop_front());
        if (txq.size() == 0) m_thre = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        int op;
        bit pv, pr, rx_rdy, rx_pop, tx_v, tx_ne;
        int tx_sz;
        logic [7:0] rb;

        i_reset = 1'b1;
        i_cs = 1'b0; i_rd = 1'b0; i_wr = 1'b0; i_addr = 3'd0; i_data = 8'h00;
        i_rx = 8'h00; i_rx_valid = 1'b0; i_tx_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_rx_ready", o_rx_ready, 1'b1);
        chk("rst_tx_valid", o_tx_valid, 1'b0);
        chk("rst_int", o_int, 1'b0);
        i_reset = 1'b0;
        idle(1);
        rd_chk(3'd5, "rst_lsr", 1'b0);
        rd_chk(3'd2, "rst_iir", 1'b0);
        bus_wr(3'd3, 8'h80);
        rd_chk(3'd0, "rst_dll", 1'b0);
        rd_chk(3'd1, "rst_dlm", 1'b0);
        bus_wr(3'd3, 8'h00);

        // RX trigger at 14
        bus_wr(3'd2, 8'hC1);
        bus_wr(3'd1, 8'h01);
        for (int i = 0; i < 13; i++) hpush(8'($urandom));
        idle(1);
        chk("trig13_int", o_int, 1'b0);
        rd_chk(3'd2, "trig13_iir", 1'b0);
        hpush(8'($urandom));
        chk("trig14_int_lat", o_int, 1'b0);
        idle(1);
        chk("trig14_int", o_int, 1'b1);
        rd_chk(3'd2, "trig14_iir", 1'b0);
        for (int i = 0; i < 14; i++) rd_chk(3'd0, "rbr14", 1'b0);
        idle(1);
        chk("drain14_int", o_int, 1'b0);
        rd_chk(3'd5, "drain14_lsr", 1'b0);

        // Character timeout with trigger 8
        bus_wr(3'd2, 8'h81);
        for (int i = 0; i < 3; i++) hpush(8'($urandom));
        idle(TMO - 2);
        rd_chk(3'd2, "tmo_early_iir", 1'b0);
        idle(2);
        rd_chk(3'd2, "tmo_iir", 1'b1);
        chk("tmo_int", o_int, 1'b1);
        rd_chk(3'd0, "tmo_rbr", 1'b0);
        rd_chk(3'd2, "tmo_clr_iir", 1'b0);
        chk("tmo_clr_int", o_int, 1'b0);
        rd_chk(3'd0, "tmo_rbr2", 1'b0);
        rd_chk(3'd0, "tmo_rbr3", 1'b0);

        // THRE interrupt and TX full behaviour
        bus_wr(3'd2, 8'h01);
        bus_wr(3'd1, 8'h02);
        idle(1);
        chk("thre_rise_int", o_int, 1'b1);
        rd_chk(3'd2, "thre_rise_iir", 1'b0);
        rd_chk(3'd2, "thre_cleared_iir", 1'b0);
        for (int i = 0; i < 17; i++) bus_wr(3'd0, 8'($urandom));
        rd_chk(3'd5, "txfull_lsr", 1'b0);
        for (int i = 0; i < 16; i++) hpop();
        idle(1);
        chk("tx_drained_valid", o_tx_valid, 1'b0);
        chk("thre_drain_int", o_int, 1'b1);
        rd_chk(3'd2, "thre_drain_iir", 1'b0);
        rd_chk(3'd2, "thre_after_iir", 1'b0);

        // Loopback overrun in 16450 mode
        bus_wr(3'd4, 8'h10);
        bus_wr(3'd2, 8'h00);
        bus_wr(3'd1, 8'h04);
        chk("loop_rx_ready", o_rx_ready, 1'b0);
        bus_wr(3'd0, 8'h41);
        bus_wr(3'd0, 8'h42);
        chk("loop_tx_valid", o_tx_valid, 1'b0);
        rd_chk(3'd2, "loop_iir", 1'b0);
        rd_chk(3'd5, "loop_lsr_oe", 1'b0);
        rd_chk(3'd5, "loop_lsr_clr", 1'b0);
        rd_chk(3'd0, "loop_rbr", 1'b0);
        rd_chk(3'd0, "loop_rbr_empty", 1'b0);
        bus_wr(3'd4, 8'h00);

        // Divisor latch and DLAB steering
        bus_wr(3'd3, 8'h80);
        bus_wr(3'd0, 8'h0C);
        bus_wr(3'd1, 8'h00);
        rd_chk(3'd0, "dll_rd", 1'b0);
        rd_chk(3'd1, "dlm_rd", 1'b0);
        bus_wr(3'd3, 8'h03);
        v = 8'($urandom);
        bus_wr(3'd0, v);
        chk("thr_o_tx", o_tx, v);
        hpop();
        rd_chk(3'd3, "lcr_rd", 1'b0);
        bus_wr(3'd3, 8'h80);
        rd_chk(3'd0, "dll_rd2", 1'b0);
        bus_wr(3'd3, 8'h03);
        bus_wr(3'd7, 8'($urandom));
        rd_chk(3'd7, "scr_rd", 1'b0);
        rd_chk(3'd6, "msr_rd", 1'b0);

        // Randomized concurrent traffic in FIFO mode
        bus_wr(3'd1, 8'h00);
        bus_wr(3'd2, 8'h07);
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom_range(0, 99) < 55);
            pr = ($urandom_range(0, 99) < 25);
            op = $urandom_range(0, 2);
            i_rx = 8'($urandom);
            i_rx_valid = pv;
            i_tx_ready = pr;
            i_data = 8'($urandom);
            i_addr = 3'd0;
            i_cs = (op != 0);
            i_wr = (op == 1);
            i_rd = (op == 2);
            rx_rdy = (rxq.size() < DEPTH);
            tx_ne = (txq.size() > 0);
            tx_sz = txq.size();
            rb = rx_rdy ? i_rx : 8'h00;
            #1;
            chk("rnd_rx_ready", o_rx_ready, rx_rdy);
            chk("rnd_tx_valid", o_tx_valid, tx_ne);
            if (tx_ne) chk("rnd_tx", o_tx, txq[0]);
            if (op == 2) chk("rnd_rbr", o_data, rxq.size() > 0 ? rxq[0] : 8'h00);
            @(posedge i_clk); #1;
            rx_pop = (op == 2) && (rxq.size() > 0);
            tx_v = tx_ne && pr;
            if (rx_pop) void'(rxq.pop_front());
            if (pv && rx_rdy) rxq.push_back(rb);
            if (tx_v) void'(txq.pop_front());
            if (op == 1) begin
                m_thre = 1'b0;
                if (tx_sz < DEPTH) txq.push_back(i_data);
            end
            if (tx_ne && txq.size() == 0) m_thre = 1'b1;
            i_cs = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
            i_rx_valid = 1'b0; i_tx_ready = 1'b0;
        end
        while (txq.size() > 0) hpop();
        while (rxq.size() > 0) rd_chk(3'd0, "rnd_drain_rbr", 1'b0);
        rd_chk(3'd5, "rnd_final_lsr", 1'b0);

        // Asynchronous reset mid-cycle
        hpush(8'($urandom));
        bus_wr(3'd0, 8'($urandom));
        bus_wr(3'd7, 8'h5A);
        #3;
        i_reset = 1'b1;
        model_reset();
        #1;
        chk("arst_tx_valid", o_tx_valid, 1'b0);
        chk("arst_int", o_int, 1'b0);
        i_cs = 1'b1; i_rd = 1'b1; i_addr = 3'd5;
        #1;
        chk("arst_lsr", o_data, 8'h60);
        i_addr = 3'd7;
        #1;
        chk("arst_scr", o_data, 8'h00);
        i_cs = 1'b0; i_rd = 1'b0;
        i_reset = 1'b0;
        idle(1);
        rd_chk(3'd2, "arst_iir", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
